apb_mem_responder: RTL and testbench
====================================

Name: apb_mem_responder

Overview:
- APB4 completer (slave) backing a word-organised RAM window with configurable wait states, byte strobes and error signalling.
- It is the responder end of the APB interface that the SoC's `apb_if` master driver initiates.
- Used as a standalone peripheral model and as an on-chip scratch RAM behind the peripheral APB fabric.
- Sits directly on one APB port; single clock domain.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width; only 32 is supported, so pstrb is 4 bits.
- MEM_BASE, 'h0000_0000, byte base address of the window; must be aligned to 2**MEM_SIZE.
- MEM_SIZE, 12, log2 of window size in bytes (4 KiB default); minimum 3.
- WAIT_CYCLES, 0, number of pready-low cycles in the ACCESS phase before completion (0..15).
- ALLOW_WRITES, 1, 0 makes the window read-only (writes return pslverr).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- srst_i  in  1  reset; synchronous and active-high.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable (ACCESS phase).
- paddr_i  in  ADDR_WIDTH  byte address.
- pwrite_i  in  1  1=write, 0=read.
- pwdata_i  in  DATA_WIDTH  write data.
- pstrb_i  in  DATA_WIDTH/8  byte write strobes.
- pready_o  out  1  transfer completion.
- prdata_o  out  DATA_WIDTH  read data, valid only when pready_o=1.
- pslverr_o  out  1  error, valid only when pready_o=1.
- proto_err_o  out  1  sticky protocol-violation flag, cleared only by reset.

Behaviour:
- FSM states: IDLE, ACCESS.
- Reset (srst_i=1 at a rising edge):
  - state=IDLE, wait counter=0, pready_o=0, prdata_o=0, pslverr_o=0, proto_err_o=0.
  - Any pending write is dropped.
  - RAM contents are not affected by reset.
- IDLE:
  - On psel_i=1 and penable_i=0 (SETUP), capture addr, write, wdata and strb, and compute err.
  - In the same cycle, load cnt=WAIT_CYCLES and prdata_q=mem[idx], or 0 if err or write.
  - Next state is ACCESS.
  - psel_i=1 with penable_i=1 in IDLE: ignored, set proto_err_o, stay IDLE.
- Address decode:
  - off = paddr - MEM_BASE.
  - in_range = paddr >= MEM_BASE and off < 2**MEM_SIZE.
  - idx = off[MEM_SIZE-1:2].
- err = !in_range, or paddr[1:0]!=0, or (write and ALLOW_WRITES=0).
- ACCESS, cnt!=0: pready_o=0 and cnt decrements by 1 each cycle.
- ACCESS, cnt==0:
  - pready_o=1 combinationally; pslverr_o=err; prdata_o=prdata_q for a non-error read, else 0.
  - If it is a write without err, commit: for each lane b with strb[b]=1, mem[idx][8b+7:8b] <= wdata lane.
  - pstrb=0 completes with OKAY and no change.
  - Next state is IDLE.
- Latency:
  - Completion occurs WAIT_CYCLES+1 cycles after the SETUP cycle.
  - With WAIT_CYCLES=0, pready_o is high in the first ACCESS cycle.
- Outside the completion cycle, pready_o=0, pslverr_o=0 and prdata_o=0.
- Back-to-back transfers:
  - A SETUP presented the cycle after completion is accepted normally.
  - A read following a write to the same word returns the new data, because the write commits at the completion edge and the read samples at its SETUP edge one cycle later.
- Protocol violations, each sets proto_err_o:
  - In ACCESS, psel_i=0 or penable_i=0 before completion: abort, return to IDLE, no write.
  - In ACCESS, paddr/pwrite/pwdata/pstrb changing versus the captured values: flagged; the captured values are used.
- srst_i asserted in ACCESS: immediate return to IDLE, no write commit, no pready_o pulse.
- Captured fields are held for the entire ACCESS phase regardless of bus changes.

Test Plan:
- Zero-wait write then read:
  - Stimulus: WAIT_CYCLES=0; write 0xDEADBEEF to MEM_BASE+0x10 with pstrb=0xF, then read MEM_BASE+0x10.
  - Required: each completes in 2 cycles (SETUP+ACCESS) with pslverr=0; read returns 0xDEADBEEF.
- Strobes:
  - Stimulus: write 0x11223344 to MEM_BASE+0x20 with pstrb=0xF, then 0xAABBCCDD with pstrb=0x5, then read.
  - Required: read returns 0x11BB33DD.
  - Stimulus: write with pstrb=0.
  - Required: OKAY, data unchanged.
- Wait states:
  - Stimulus: WAIT_CYCLES=3; read MEM_BASE.
  - Required: pready low for exactly 3 ACCESS cycles, high on the 4th; prdata is 0 on all non-ready cycles.
- Errors:
  - Stimulus: read MEM_BASE+0x1000 (size 12), write to MEM_BASE+0x2, and write with ALLOW_WRITES=0.
  - Required: each returns pslverr=1 and prdata=0; subsequent reads show memory unchanged.
- Protocol/reset:
  - Stimulus: drop psel mid-ACCESS with WAIT_CYCLES=2.
  - Required: no commit, proto_err_o=1 until srst_i.
  - Stimulus: assert srst_i during ACCESS of a write of 0x55.
  - Required: pready never pulses and the word keeps its old value.
- Back-to-back:
  - Stimulus: 16 consecutive alternating write/read transfers at WAIT_CYCLES=0 across addresses MEM_BASE..MEM_BASE+0x3C.
  - Required: every read matches the preceding write; proto_err_o=0.

Source files
------------

// File: rtl/apb_mem_responder_if.sv
// apb_mem_responder_if: APB4 bus bundle between an initiator and the RAM-window responder.
interface apb_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic psel;
    logic penable;
    logic [ADDR_WIDTH-1:0] paddr;
    logic pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic pslverr;
    modport master (
        output psel, penable, paddr, pwrite, pwdata, pstrb,
        input pready, prdata, pslverr
    );
    modport slave (
        input psel, penable, paddr, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_mem_responder.sv
// apb_mem_responder: APB4 completer backing a word-organised RAM window with wait states, strobes and errors.
module apb_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE = '0,
    parameter int MEM_SIZE = 12,
    parameter int WAIT_CYCLES = 0,
    parameter int ALLOW_WRITES = 1
) (
    input logic clk_i,
    input logic srst_i,
    apb_mem_responder_if.slave bus,
    output logic proto_err_o
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state;
    logic [ADDR_WIDTH-1:0] off, addr_q;
    logic [MEM_SIZE-3:0] idx, idx_q;
    logic [DATA_WIDTH-1:0] wdata_q, prdata_q;
    logic [DATA_WIDTH/8-1:0] strb_q;
    logic [3:0] cnt;
    logic err, err_q, write_q, changed, done, commit;
    logic [DATA_WIDTH-1:0] mem [2**(MEM_SIZE-2)];
    always_comb begin
        off = bus.paddr - MEM_BASE;
        idx = off[MEM_SIZE-1:2];
        err = bus.paddr < MEM_BASE || (off >> MEM_SIZE) != '0 || off[1:0] != 2'b00
            || (bus.pwrite && ALLOW_WRITES == 0);
        changed = bus.paddr != addr_q || bus.pwrite != write_q || bus.pwdata != wdata_q || bus.pstrb != strb_q;
        done = state == ACCESS && cnt == 4'd0 && !srst_i;
        commit = done && write_q && !err_q;
    end
    // prdata_q is already zero for writes and errored transfers
    assign bus.pready = done;
    assign bus.pslverr = done && err_q;
    assign bus.prdata = done ? prdata_q : '0;
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state <= IDLE;
            cnt <= '0;
            prdata_q <= '0;
            err_q <= 1'b0;
            write_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            strb_q <= '0;
            idx_q <= '0;
            proto_err_o <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.psel && !bus.penable) begin
                addr_q <= bus.paddr;
                write_q <= bus.pwrite;
                wdata_q <= bus.pwdata;
                strb_q <= bus.pstrb;
                idx_q <= idx;
                err_q <= err;
                cnt <= 4'(WAIT_CYCLES);
                prdata_q <= (err || bus.pwrite) ? '0 : mem[idx];
                state <= ACCESS;
            end else if (bus.psel && bus.penable) begin
                proto_err_o <= 1'b1;
            end
        end else if (cnt != 4'd0) begin
            if (!bus.psel || !bus.penable) begin
                proto_err_o <= 1'b1;
                state <= IDLE;
            end else begin
                cnt <= cnt - 4'd1;
                if (changed) proto_err_o <= 1'b1;
            end
        end else begin
            if (bus.psel && bus.penable && changed) proto_err_o <= 1'b1;
            state <= IDLE;
        end
    end
    always_ff @(posedge clk_i)
        if (commit)
            for (int b = 0; b < DATA_WIDTH/8; b++)
                if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
endmodule

// File: tb/tb_apb_mem_responder.sv
// tb_apb_mem_responder: directed vector table plus hand sequences across four responder configurations.
module tb_apb_mem_responder;
    localparam logic [31:0] BASE = 32'h0000_4000;
    logic clk = 1'b0;
    logic srst = 1'b1;
    logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [3:0] pstrb = '0;
    int sel = 0;
    logic [3:0] rdy, se, pe;
    logic [31:0] prd [4];
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    // dut 0: zero wait, 1: three waits, 2: two waits, 3: read-only
    for (genvar g = 0; g < 4; g++) begin : gd
        apb_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
        assign bus.psel = psel && sel == g;
        assign bus.penable = penable;
        assign bus.paddr = paddr;
        assign bus.pwrite = pwrite;
        assign bus.pwdata = pwdata;
        assign bus.pstrb = pstrb;
        assign rdy[g] = bus.pready;
        assign se[g] = bus.pslverr;
        assign prd[g] = bus.prdata;
        apb_mem_responder #(
            .MEM_BASE(BASE),
            .WAIT_CYCLES(g == 1 ? 3 : g == 2 ? 2 : 0),
            .ALLOW_WRITES(g == 3 ? 0 : 1)
        ) dut (
            .clk_i(clk),
            .srst_i(srst),
            .bus(bus),
            .proto_err_o(pe[g])
        );
    end
    typedef struct {
        int k;
        logic w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0] s;
        logic [31:0] rd;
        logic er;
        int cyc;
    } vec_t;
    vec_t tv [16];
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask
    task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic er, output int cyc);
        @(negedge clk);
        sel = k; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
        @(negedge clk);
        penable = 1'b1;
        cyc = 1;
        #1;
        while (!rdy[k] && cyc < 40) begin
            chk("wait prdata zero", prd[k], 32'h0);
            chk("wait pslverr zero", {31'h0, se[k]}, 32'h0);
            @(negedge clk);
            #1;
            cyc++;
        end
        rd = prd[k];
        er = se[k];
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        logic [31:0] rd, d;
        logic er;
        int cyc;
        tv[0]  = '{0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1};
        tv[1]  = '{0, 1'b0, BASE + 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1};
        tv[2]  = '{0, 1'b1, BASE + 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 1};
        tv[3]  = '{0, 1'b1, BASE + 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0, 1};
        tv[4]  = '{0, 1'b0, BASE + 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1};
        tv[5]  = '{0, 1'b1, BASE + 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 1};
        tv[6]  = '{0, 1'b0, BASE + 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1};
        tv[7]  = '{0, 1'b1, BASE, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1};
        tv[8]  = '{0, 1'b1, BASE + 32'h2, 32'h12345678, 4'hF, 32'h0, 1'b1, 1};
        tv[9]  = '{0, 1'b0, BASE, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1};
        tv[10] = '{0, 1'b0, BASE + 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 1};
        tv[11] = '{0, 1'b0, BASE - 32'h4, 32'h0, 4'h0, 32'h0, 1'b1, 1};
        tv[12] = '{1, 1'b1, BASE, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 4};
        tv[13] = '{1, 1'b0, BASE, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 4};
        tv[14] = '{3, 1'b1, BASE + 32'h8, 32'h12345678, 4'hF, 32'h0, 1'b1, 1};
        tv[15] = '{3, 1'b0, BASE + 32'h2, 32'h0, 4'h0, 32'h0, 1'b1, 1};
        repeat (3) @(posedge clk);
        @(negedge clk);
        srst = 1'b0;
        #1;
        chk("reset pready", {28'h0, rdy}, 32'h0);
        chk("reset pslverr", {28'h0, se}, 32'h0);
        chk("reset proto_err", {28'h0, pe}, 32'h0);
        chk("reset prdata", prd[0], 32'h0);
        for (int i = 0; i < 16; i++) begin
            xfer(tv[i].k, tv[i].w, tv[i].a, tv[i].d, tv[i].s, rd, er, cyc);
            chk($sformatf("vec%0d prdata", i), rd, tv[i].rd);
            chk($sformatf("vec%0d pslverr", i), {31'h0, er}, {31'h0, tv[i].er});
            chk($sformatf("vec%0d cycles", i), cyc, tv[i].cyc);
        end
        chk("table proto_err", {28'h0, pe}, 32'h0);
        // abort mid-ACCESS by dropping psel
        xfer(2, 1'b1, BASE + 32'h30, 32'h01020304, 4'hF, rd, er, cyc);
        chk("abort prewrite cycles", cyc, 3);
        chk("abort proto before", {31'h0, pe[2]}, 32'h0);
        @(negedge clk);
        sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h30; pwdata = 32'h99999999; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        #1 chk("abort access pready", {31'h0, rdy[2]}, 32'h0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("abort no pready", {31'h0, rdy[2]}, 32'h0);
            @(negedge clk);
        end
        chk("abort proto set", {31'h0, pe[2]}, 32'h1);
        xfer(2, 1'b0, BASE + 32'h30, 32'h0, 4'h0, rd, er, cyc);
        chk("abort no commit", rd, 32'h01020304);
        chk("abort read cycles", cyc, 3);
        chk("abort proto sticky", {31'h0, pe[2]}, 32'h1);
        @(negedge clk) srst = 1'b1;
        @(negedge clk) srst = 1'b0;
        #1 chk("proto cleared by reset", {28'h0, pe}, 32'h0);
        // reset during ACCESS of a write
        xfer(1, 1'b1, BASE + 32'h4, 32'h12345678, 4'hF, rd, er, cyc);
        chk("rst prewrite cycles", cyc, 4);
        @(negedge clk);
        sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h4; pwdata = 32'h55; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        #1 chk("rst access pready", {31'h0, rdy[1]}, 32'h0);
        @(negedge clk);
        srst = 1'b1; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        srst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("rst no pready", {31'h0, rdy[1]}, 32'h0);
            @(negedge clk);
        end
        xfer(1, 1'b0, BASE + 32'h4, 32'h0, 4'h0, rd, er, cyc);
        chk("rst word kept", rd, 32'h12345678);
        // back-to-back alternating write/read over the first 16 words
        for (int i = 0; i < 16; i++) begin
            d = {8'h5A, 8'(i), 16'(i * 977 + 3)};
            xfer(0, 1'b1, BASE + 32'(4 * i), d, 4'hF, rd, er, cyc);
            chk($sformatf("b2b write%0d err", i), {31'h0, er}, 32'h0);
            xfer(0, 1'b0, BASE + 32'(4 * i), 32'h0, 4'h0, rd, er, cyc);
            chk($sformatf("b2b read%0d", i), rd, d);
        end
        chk("b2b proto_err", {31'h0, pe[0]}, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
